capture_buf: RTL and testbench
==============================

CAPTURE_BUF -- requirements
Module: capture_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, bits per channel sample.
REQ-002 SHALL have parameter CHANNELS, default 4, number of parallel input channels (1..16).
REQ-003 SHALL have parameter DEPTH, default 2048, samples per channel, power of two; ADDR_W = clog2(DEPTH), CH_W = max(1, clog2(CHANNELS)).
REQ-004 SHALL have port rd_clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port wr_clk  in  1  sample strobe, asynchronous to rd_clk, treated as data and never used as a clock.
REQ-007 SHALL have port wr_data  in  CHANNELS*DATA_WIDTH  packed samples; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port point_num  in  ADDR_W+1  samples per channel to capture.
REQ-009 SHALL have port request  in  1  start capture on rising edge.
REQ-010 SHALL have port abort  in  1  level; cancels any capture or readout.
REQ-011 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-012 SHALL have ports m_tdata out DATA_WIDTH, m_tvalid out 1, m_tready in 1, m_tlast out 1, m_tchan out CH_W  AXI-stream readout.

Function
REQ-013 SHALL synchronise wr_clk through two flops; a sample event is a 0->1 transition of the second flop.
REQ-014 SHALL detect a request event as a 0->1 transition of request registered in rd_clk.
REQ-015 SHALL implement FSM IDLE -> CAPTURE -> READ -> IDLE.
REQ-016 IDLE: a request event moves to CAPTURE; point_num latched as N, clamped to DEPTH if larger; if point_num == 0, the request SHALL be ignored.
REQ-017 CAPTURE: each sample event writes all channels of wr_data to address wr_cnt and then increments wr_cnt from 0; after the Nth write the FSM moves to READ on the next cycle.
REQ-018 wr_data SHALL be sampled in the same cycle as the sample event; the source keeps wr_data stable for at least 4 rd_clk cycles after the wr_clk rise.
REQ-019 READ: beats are issued channel-major: channel 0 samples 0..N-1, then channel 1, ..., up to channel CHANNELS-1; total N*CHANNELS beats.
REQ-020 m_tchan SHALL equal the channel index of the current beat; m_tlast SHALL be high only on sample N-1 of channel CHANNELS-1.
REQ-021 The first m_tvalid SHALL assert no later than 3 cycles after entering READ.
REQ-022 A beat transfers when m_tvalid && m_tready; while m_tvalid && !m_tready, m_tdata, m_tlast and m_tchan SHALL hold stable.
REQ-023 With m_tready held high, READ SHALL sustain one beat per cycle with no bubbles after the first beat; a skid register handles the 1-cycle RAM latency.
REQ-024 The FSM SHALL return to IDLE in the cycle after the m_tlast transfer.
REQ-025 Request events outside IDLE SHALL be ignored and never queued.
REQ-026 abort high in any state: next cycle the FSM is IDLE, m_tvalid = 0, and counters are 0; abort takes priority over a simultaneous request or sample event.
REQ-027 A request event and abort in the same cycle while in IDLE: abort wins and no capture starts.
REQ-028 Counters SHALL be sized so N = DEPTH produces no wrap before completion: wr_cnt and rd sample index ADDR_W+1 bits, channel index CH_W bits.
REQ-029 A sample event in IDLE or READ SHALL NOT write the RAM.

Reset
REQ-030 While rst_n is low at a clock edge: state IDLE, busy 0, m_tvalid 0, m_tlast 0, m_tdata 0, m_tchan 0, counters 0, edge-detect flops 0.
REQ-031 Reset mid-capture or mid-readout SHALL behave as abort; RAM contents need not be cleared.

Structure
REQ-032 Package capture_buf_pkg SHALL hold the FSM state enum (IDLE, CAPTURE, READ) and a clog2 helper function.
REQ-033 Storage SHALL be one sub-module capture_buf_ram: simple dual-port, DEPTH x (CHANNELS*DATA_WIDTH), one write port, registered read port with 1-cycle latency; the channel slice is selected after the read.

Verification
REQ-034 DW=12, CH=4, N=8, ramp data with m_tready=1 -> 32 beats, ch0 s0..7 then ch1..ch3, m_tlast only on beat 32, busy low next cycle.
REQ-035 N=8, m_tready toggling 1/0 each cycle -> same 32 beats in order, outputs stable during every stall cycle.
REQ-036 point_num=4095 with DEPTH=2048 -> exactly 2048 samples per channel captured, 8192 beats.
REQ-037 point_num=0 request -> busy stays 0 and no m_tvalid; a second request during CAPTURE is ignored.
REQ-038 abort after 3 samples, then a new request with N=2 -> exactly 2*CH beats of fresh data with no stale data.
REQ-039 rst_n low during READ beat 5 -> m_tvalid=0 on the following cycle, then IDLE.

Source files
------------

// File: rtl/capture_buf_pkg.sv
// Shared types and helpers for the capture buffer.
package capture_buf_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, READ} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/capture_buf_ram.sv
// Simple dual-port sample store: one write port, registered read port.
module capture_buf_ram #(
  parameter int AW = 11,
  parameter int DW = 48
) (
  input  logic          rd_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge rd_clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_buf.sv
// Multi-channel sample capture buffer with channel-major AXI-stream readout.
module capture_buf import capture_buf_pkg::*; #(
  parameter  int DATA_WIDTH = 12,
  parameter  int CHANNELS   = 4,
  parameter  int DEPTH      = 2048,
  localparam int ADDR_W     = clog2(DEPTH),
  localparam int CH_W       = (CHANNELS > 1) ? clog2(CHANNELS) : 1
) (
  input  logic                           rd_clk,
  input  logic                           rst_n,
  input  logic                           wr_clk,
  input  logic [CHANNELS*DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W:0]                point_num,
  input  logic                           request,
  input  logic                           abort,
  output logic                           busy,
  output logic [DATA_WIDTH-1:0]          m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast,
  output logic [CH_W-1:0]                m_tchan
);

  localparam int RW = CHANNELS * DATA_WIDTH;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);

  state_t          state;
  logic [2:0]      wr_sync;
  logic            req_q;
  logic            sample_ev, req_ev, xfer, issue, we;
  logic [ADDR_W:0] n_q, wr_cnt, rd_idx;
  logic [CH_W-1:0] rd_ch;
  logic            issued_all;
  logic            rd_vld, rd_last_q;
  logic [CH_W-1:0] rd_ch_q;
  logic [RW-1:0]   ram_q;
  logic [DATA_WIDTH-1:0] ram_slice, skid_data;
  logic [CH_W-1:0] skid_ch;
  logic            skid_vld, skid_last;
  logic [1:0]      occ;

  assign busy      = (state != IDLE);
  assign sample_ev = wr_sync[1] & ~wr_sync[2];
  assign req_ev    = request & ~req_q;
  assign xfer      = m_tvalid & m_tready;
  assign we        = (state == CAPTURE) && sample_ev && !abort;
  assign ram_slice = ram_q[32'(rd_ch_q) * DATA_WIDTH +: DATA_WIDTH];

  // Beats held or in flight after this cycle; a read is issued only if it will
  // have a slot (output or skid) by the time the RAM returns it.
  assign occ   = {1'b0, m_tvalid} + {1'b0, skid_vld} + {1'b0, rd_vld} - {1'b0, xfer};
  assign issue = (state == READ) && !issued_all && (occ <= 2'd1);

  capture_buf_ram #(.AW(ADDR_W), .DW(RW)) u_ram (
    .rd_clk (rd_clk),
    .we     (we),
    .waddr  (wr_cnt[ADDR_W-1:0]),
    .wdata  (wr_data),
    .re     (issue),
    .raddr  (rd_idx[ADDR_W-1:0]),
    .rdata  (ram_q)
  );

  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      wr_sync <= '0;
      req_q   <= 1'b0;
    end else begin
      wr_sync <= {wr_sync[1:0], wr_clk};
      req_q   <= request;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rst_n || abort) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      rd_idx     <= '0;
      rd_ch      <= '0;
      issued_all <= 1'b0;
      rd_vld     <= 1'b0;
      skid_vld   <= 1'b0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      if (!rst_n) begin
        n_q       <= '0;
        m_tdata   <= '0;
        m_tchan   <= '0;
        rd_ch_q   <= '0;
        rd_last_q <= 1'b0;
        skid_data <= '0;
        skid_ch   <= '0;
        skid_last <= 1'b0;
      end
    end else begin
      // Address generation, channel-major.
      if (issue) begin
        rd_ch_q   <= rd_ch;
        rd_last_q <= (rd_ch == LAST_CH) && (rd_idx == n_q - 1'b1);
        if (rd_idx == n_q - 1'b1) begin
          rd_idx <= '0;
          if (rd_ch == LAST_CH) issued_all <= 1'b1;
          else                  rd_ch      <= rd_ch + 1'b1;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
      rd_vld <= issue;

      // Output register fed from skid first, then straight from the RAM.
      if (!m_tvalid || xfer) begin
        if (skid_vld) begin
          {m_tdata, m_tchan, m_tlast} <= {skid_data, skid_ch, skid_last};
          m_tvalid <= 1'b1;
          skid_vld <= rd_vld;
          if (rd_vld) {skid_data, skid_ch, skid_last} <= {ram_slice, rd_ch_q, rd_last_q};
        end else if (rd_vld) begin
          {m_tdata, m_tchan, m_tlast} <= {ram_slice, rd_ch_q, rd_last_q};
          m_tvalid <= 1'b1;
        end else begin
          m_tvalid <= 1'b0;
          m_tlast  <= 1'b0;
        end
      end else if (rd_vld) begin
        {skid_data, skid_ch, skid_last} <= {ram_slice, rd_ch_q, rd_last_q};
        skid_vld <= 1'b1;
      end

      case (state)
        IDLE: if (req_ev && point_num != '0) begin
          state  <= CAPTURE;
          n_q    <= (point_num > DEPTH_N) ? DEPTH_N : point_num;
          wr_cnt <= '0;
        end
        CAPTURE: if (sample_ev) begin
          wr_cnt <= wr_cnt + 1'b1;
          if (wr_cnt + 1'b1 == n_q) state <= READ;
        end
        READ: if (xfer && m_tlast) begin
          state      <= IDLE;
          wr_cnt     <= '0;
          rd_idx     <= '0;
          rd_ch      <= '0;
          issued_all <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_buf.sv
// Directed bench for capture_buf with a beat scoreboard.
module tb_capture_buf;

  localparam int DW = 12, CH = 4, DEPTH = 2048, AW = 11, CW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] chan;
    logic          last;
  } beat_t;

  logic rd_clk = 1'b0, rst_n = 1'b0, wr_clk = 1'b0, request = 1'b0, abort = 1'b0;
  logic m_tready = 1'b1;
  logic [CH*DW-1:0] wr_data = '0;
  logic [AW:0] point_num = '0;
  logic busy, m_tvalid, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [CW-1:0] m_tchan;

  int checks = 0, errors = 0, beats = 0, ready_mode = 0;
  beat_t exp_q[$];
  beat_t prev, e;
  logic prev_stall = 1'b0, last_done = 1'b0;
  logic [CH*DW-1:0] rows [DEPTH];

  capture_buf #(.DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DEPTH)) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .wr_clk(wr_clk), .wr_data(wr_data),
    .point_num(point_num), .request(request), .abort(abort), .busy(busy),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tchan(m_tchan)
  );

  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) begin
    #1;
    m_tready = (ready_mode == 1) ? ~m_tready : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer plus stall-stability and end-of-readout checks.
  always @(negedge rd_clk) begin
    if (last_done) begin
      check("busy_after_last", 32'(busy), 32'd0);
      last_done = 1'b0;
    end
    if (prev_stall)
      check("stall_hold", {16'd0, m_tvalid, m_tdata, m_tchan, m_tlast}, {16'd0, 1'b1, prev});
    prev_stall = rst_n && m_tvalid && !m_tready;
    prev = {m_tdata, m_tchan, m_tlast};
    if (rst_n && m_tvalid && m_tready) begin
      beats++;
      check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("beat", 32'({m_tdata, m_tchan, m_tlast}), 32'(e));
      end
      if (m_tlast) last_done = 1'b1;
    end
  end

  task automatic push(input int n);
    for (int k = 0; k < CH; k++)
      for (int s = 0; s < n; s++)
        exp_q.push_back({rows[s][k*DW +: DW], CW'(k), (k == CH-1) && (s == n-1)});
  endtask

  task automatic fill_rand(input int n);
    for (int s = 0; s < n; s++)
      for (int k = 0; k < CH; k++) rows[s][k*DW +: DW] = DW'($urandom);
  endtask

  task automatic pulse(input int n);
    point_num = (AW+1)'(n);
    request = 1'b1;
    repeat (2) @(posedge rd_clk);
    #1 request = 1'b0;
    @(posedge rd_clk); #1;
  endtask

  task automatic send(input logic [CH*DW-1:0] d);
    wr_data = d;
    wr_clk = 1'b1;
    repeat (5) @(posedge rd_clk);
    #1 wr_clk = 1'b0;
    repeat (3) @(posedge rd_clk);
    #1;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n;
    n = 0;
    while (busy && n < max) begin
      @(posedge rd_clk); #1;
      n++;
    end
    check(tag, 32'(n < max), 32'd1);
    repeat (2) @(posedge rd_clk);
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge rd_clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tchan", 32'(m_tchan), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge rd_clk);
    #1;

    // Ramp capture, N=8, ready held high.
    for (int s = 0; s < 8; s++)
      for (int k = 0; k < CH; k++) rows[s][k*DW +: DW] = DW'(s * 16 + k);
    beats = 0; push(8); pulse(8);
    check("t1_busy", 32'(busy), 32'd1);
    for (int s = 0; s < 8; s++) send(rows[s]);
    wait_idle(200, "t1_idle");
    check("t1_beats", 32'(beats), 32'd32);
    check("t1_queue", 32'(exp_q.size()), 32'd0);

    // Same size with ready toggling every cycle.
    fill_rand(8);
    beats = 0; push(8); pulse(8);
    ready_mode = 1;
    for (int s = 0; s < 8; s++) send(rows[s]);
    wait_idle(400, "t2_idle");
    ready_mode = 0;
    check("t2_beats", 32'(beats), 32'd32);
    check("t2_queue", 32'(exp_q.size()), 32'd0);

    // point_num beyond DEPTH clamps to DEPTH.
    fill_rand(DEPTH);
    beats = 0; push(DEPTH); pulse(4095);
    for (int s = 0; s < DEPTH; s++) send(rows[s]);
    wait_idle(20000, "t3_idle");
    check("t3_beats", 32'(beats), 32'd8192);
    check("t3_queue", 32'(exp_q.size()), 32'd0);

    // Zero-length request ignored; second request during capture ignored.
    beats = 0; pulse(0);
    repeat (4) @(posedge rd_clk);
    #1;
    check("t4_zero_busy", 32'(busy), 32'd0);
    check("t4_zero_tvalid", 32'(m_tvalid), 32'd0);
    fill_rand(3);
    push(3); pulse(3);
    send(rows[0]);
    pulse(8);
    check("t4_busy", 32'(busy), 32'd1);
    send(rows[1]); send(rows[2]);
    wait_idle(200, "t4_idle");
    check("t4_beats", 32'(beats), 32'd12);
    check("t4_queue", 32'(exp_q.size()), 32'd0);

    // Abort after 3 samples, then a fresh 2-sample capture.
    fill_rand(3);
    beats = 0; pulse(4);
    for (int s = 0; s < 3; s++) send(rows[s]);
    abort = 1'b1;
    @(posedge rd_clk); #1;
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_tvalid", 32'(m_tvalid), 32'd0);
    abort = 1'b0;
    for (int s = 0; s < 3; s++) rows[s] = ~rows[s];
    push(2); pulse(2);
    send(rows[0]); send(rows[1]);
    wait_idle(200, "t5_idle");
    check("t5_beats", 32'(beats), 32'd8);
    check("t5_queue", 32'(exp_q.size()), 32'd0);

    // Reset while beat 5 is on the bus.
    fill_rand(8);
    beats = 0; push(8); pulse(8);
    for (int s = 0; s < 7; s++) send(rows[s]);
    wr_data = rows[7];
    wr_clk = 1'b1;
    n = 0;
    while (beats < 4 && n < 50) begin
      @(posedge rd_clk); #1;
      n++;
    end
    check("t6_reach_beat5", 32'(n < 50), 32'd1);
    rst_n = 1'b0;
    @(posedge rd_clk); #1;
    check("t6_tvalid", 32'(m_tvalid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    exp_q.delete();
    wr_clk = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge rd_clk);
    #1;
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_beats", 32'(beats), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
